// File: rtl/iot_pkg.sv
// Shared constants, FSM state type and Gray encoder for the IoT byte transmitter.
package iot_pkg;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 128;
    localparam int BYTES_PER_WORD = 16;
    localparam logic [2:0] FN_GRAY = 3'b001;

    typedef enum logic {IDLE, SEND} state_t;

    // Inverse of the receiver's Gray-to-binary conversion.
    function automatic logic [WORD_W-1:0] gray_enc(input logic [WORD_W-1:0] w);
        return w ^ (w >> 1);
    endfunction
endpackage

// File: rtl/iot_byte_tx_if.sv
// Upstream word handshake plus the receiver-facing byte interface.
interface iot_byte_tx_if;
    import iot_pkg::*;

    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_in;
    logic [2:0]        fn_in;
    logic              busy;
    logic              in_en;
    logic [BYTE_W-1:0] iot_in;
    logic [2:0]        fn_sel;

    modport slave  (input  word_valid, word_in, fn_in, busy,
                    output word_ready, in_en, iot_in, fn_sel);
    modport master (output word_valid, word_in, fn_in, busy,
                    input  word_ready, in_en, iot_in, fn_sel);
endinterface

// File: rtl/iot_word_fifo.sv
// Synchronous word FIFO; pointers carry an extra wrap bit to tell full from empty.
module iot_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 131
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !full && !clr)
            mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/iot_byte_tx.sv
// Buffers 128-bit words, optionally Gray-encodes them and streams each as 16
// MSB-first bytes to the IoT receiver, honouring its busy back-pressure.
module iot_byte_tx
    import iot_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    iot_byte_tx_if.slave     bus,
    input  logic             flush,
    output logic             done,
    output logic [CNT_W-1:0] tx_count
);
    state_t              state;
    logic [WORD_W-1:0]   shreg;
    logic [3:0]          byte_idx;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                consumed;
    logic                last_byte;
    logic [WORD_W+2:0]   fifo_head;
    logic [2:0]          head_fn;
    logic [WORD_W-1:0]   next_word;

    assign bus.word_ready = !fifo_full;
    assign push      = bus.word_valid && !fifo_full && !flush;
    assign consumed  = bus.in_en && !bus.busy;
    assign last_byte = (byte_idx == 4'(BYTES_PER_WORD - 1));
    assign pop       = !flush && !fifo_empty &&
                       ((state == IDLE) || (state == SEND && consumed && last_byte));
    assign head_fn   = fifo_head[WORD_W+2:WORD_W];
    assign next_word = (head_fn == FN_GRAY) ? gray_enc(fifo_head[WORD_W-1:0])
                                            : fifo_head[WORD_W-1:0];

    iot_word_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W + 3)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clr   (flush),
        .din   ({bus.fn_in, bus.word_in}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // A pop at the last byte reloads the shift register at the same edge, so
    // back-to-back words stream with in_en held high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            byte_idx   <= '0;
            bus.in_en  <= 1'b0;
            bus.iot_in <= '0;
            bus.fn_sel <= '0;
            done       <= 1'b0;
            tx_count   <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state     <= IDLE;
                bus.in_en <= 1'b0;
                byte_idx  <= '0;
            end else if (pop) begin
                shreg      <= next_word;
                bus.iot_in <= next_word[WORD_W-1 -: BYTE_W];
                bus.fn_sel <= head_fn;
                byte_idx   <= '0;
                bus.in_en  <= 1'b1;
                state      <= SEND;
                if (state == SEND) begin
                    done     <= 1'b1;
                    tx_count <= tx_count + CNT_W'(1);
                end
            end else if (state == SEND && consumed) begin
                if (last_byte) begin
                    state     <= IDLE;
                    bus.in_en <= 1'b0;
                    done      <= 1'b1;
                    tx_count  <= tx_count + CNT_W'(1);
                end else begin
                    shreg      <= shreg << BYTE_W;
                    bus.iot_in <= shreg[WORD_W-BYTE_W-1 -: BYTE_W];
                    byte_idx   <= byte_idx + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_iot_byte_tx.sv
// Scoreboard bench for iot_byte_tx: accepted words expand into expected bytes,
// a negedge monitor checks every consumed byte, done pulse and word count.
module tb_iot_byte_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        done;
    logic [15:0] tx_count;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];
    logic [10:0] exp_e;
    logic [15:0] model_count = '0;
    logic        expect_done = 1'b0;
    logic        flushed_prev = 1'b0;
    int          byte_cnt = 0;

    iot_byte_tx_if bus();

    iot_byte_tx #(.DEPTH(4), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flush    (flush),
        .done     (done),
        .tx_count (tx_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected byte stream for a word, straight from the encoding rule.
    task automatic queueWord(input logic [127:0] w, input logic [2:0] fn);
        logic [127:0] v;
        v = (fn == 3'b001) ? (w ^ (w >> 1)) : w;
        for (int i = 0; i < 16; i++)
            exp_q.push_back({fn, v[127 - 8*i -: 8]});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_count  = '0;
            expect_done  = 1'b0;
            flushed_prev = 1'b0;
            byte_cnt     = 0;
        end else begin
            checkOutput("done", {31'd0, done}, {31'd0, expect_done});
            checkOutput("tx_count", {16'd0, tx_count}, {16'd0, model_count});
            if (flushed_prev)
                checkOutput("flush_in_en", {31'd0, bus.in_en}, 32'd0);
            expect_done  = 1'b0;
            flushed_prev = 1'b0;
            if (flush) begin
                exp_q.delete();
                byte_cnt     = 0;
                flushed_prev = 1'b1;
            end else if (bus.in_en && !bus.busy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_byte actual=%0h expected=none at %0t", bus.iot_in, $time);
                end else begin
                    exp_e = exp_q.pop_front();
                    checkOutput("iot_in", {24'd0, bus.iot_in}, {24'd0, exp_e[7:0]});
                    checkOutput("fn_sel", {29'd0, bus.fn_sel}, {29'd0, exp_e[10:8]});
                end
                byte_cnt++;
                if (byte_cnt == 16) begin
                    byte_cnt    = 0;
                    model_count = model_count + 16'd1;
                    expect_done = 1'b1;
                end
            end
            if (bus.word_valid && bus.word_ready && !flush)
                queueWord(bus.word_in, bus.fn_in);
        end
    end

    // Offer one word and hold it until accepted; returns 1 time unit after the push edge.
    task automatic applyStimulus(input logic [127:0] w, input logic [2:0] fn);
        bus.word_valid = 1'b1;
        bus.word_in    = w;
        bus.fn_in      = fn;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.word_ready && !flush) begin
                @(posedge clk);
                #1;
                bus.word_valid = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("[TB] FAIL push_timeout actual=not_accepted expected=accepted at %0t", $time);
        bus.word_valid = 1'b0;
    endtask

    task automatic waitDrain();
        bit idle = 1'b0;
        for (int t = 0; t < 3000 && !idle; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.in_en)
                idle = 1'b1;
        end
        checkOutput("drain_idle", {31'd0, idle}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] randWord();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int n;
        rst            = 1'b1;
        flush          = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_in    = '0;
        bus.fn_in      = '0;
        bus.busy       = 1'b0;
        #2;
        checkOutput("rst_word_ready", {31'd0, bus.word_ready}, 32'd1);
        checkOutput("rst_in_en", {31'd0, bus.in_en}, 32'd0);
        checkOutput("rst_iot_in", {24'd0, bus.iot_in}, 32'd0);
        checkOutput("rst_fn_sel", {29'd0, bus.fn_sel}, 32'd0);
        checkOutput("rst_tx_count", {16'd0, tx_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Binary pass-through with first-byte latency.
        applyStimulus(128'h000102030405060708090A0B0C0D0E0F, 3'b000);
        checkOutput("latency_idle", {31'd0, bus.in_en}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("latency_in_en", {31'd0, bus.in_en}, 32'd1);
        checkOutput("latency_byte0", {24'd0, bus.iot_in}, 32'h00);
        waitDrain();

        // Gray-encoded word.
        applyStimulus(128'h80000000_00000000_00000000_00000001, 3'b001);
        waitDrain();

        // Busy stall while byte 3 is presented.
        applyStimulus(128'h000102030405060708090A0B0C0D0E0F, 3'b010);
        repeat (4) @(posedge clk);
        #1 bus.busy = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_hold", {24'd0, bus.iot_in}, 32'h03);
            @(posedge clk);
        end
        #1 bus.busy = 1'b0;
        waitDrain();

        // Fill to capacity under busy, then stream back-to-back.
        bus.busy = 1'b1;
        for (int i = 0; i < 5; i++)
            applyStimulus(randWord(), 3'($urandom_range(0, 7)));
        checkOutput("full_ready", {31'd0, bus.word_ready}, 32'd0);
        n = 0;
        bus.busy = 1'b0;
        fork
            applyStimulus(randWord(), 3'b001);
            for (int c = 0; c < 96; c++) begin
                @(negedge clk);
                if (bus.in_en && !bus.busy)
                    n++;
            end
        join
        checkOutput("b2b_consume_cycles", n, 32'd96);
        waitDrain();

        // Flush mid-word with two words queued.
        bus.busy = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus(randWord(), 3'($urandom_range(0, 7)));
        bus.busy = 1'b0;
        repeat (8) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checkOutput("flush_word_ready", {31'd0, bus.word_ready}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("flush_stays_idle", {31'd0, bus.in_en}, 32'd0);

        // Asynchronous reset in the middle of a word.
        applyStimulus(128'hFFEEDDCCBBAA99887766554433221100, 3'b001);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_in_en", {31'd0, bus.in_en}, 32'd0);
        checkOutput("arst_iot_in", {24'd0, bus.iot_in}, 32'd0);
        checkOutput("arst_fn_sel", {29'd0, bus.fn_sel}, 32'd0);
        checkOutput("arst_done", {31'd0, done}, 32'd0);
        checkOutput("arst_tx_count", {16'd0, tx_count}, 32'd0);
        checkOutput("arst_word_ready", {31'd0, bus.word_ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(128'h0123456789ABCDEF_FEDCBA9876543210, 3'b000);
        waitDrain();

        // Randomized traffic with busy, flush and gaps.
        for (int c = 0; c < 400; c++) begin
            bus.busy       = ($urandom_range(0, 3) == 0);
            flush          = ($urandom_range(0, 60) == 0);
            bus.word_valid = ($urandom_range(0, 1) == 1);
            bus.word_in    = randWord();
            bus.fn_in      = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        bus.word_valid = 1'b0;
        bus.busy       = 1'b0;
        flush          = 1'b0;
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
